instr_sequencer: RTL and testbench

//  Instruction-side counterpart of the ALU: fetches 32-bit instruction words, decodes them into
//  the ALU's opcode/immediate/flag inputs and register-file indices, then consumes the ALU's

---
 rtl/instr_sequencer_pkg.sv | 44 ++++
 rtl/instr_decode.sv | 26 ++
 rtl/instr_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared opcode constants, instruction field positions, op-class and FSM state types
// for the instruction sequencer.
package instr_sequencer_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_LOAD = 6'd5;
  localparam logic [5:0] OP_SHL  = 6'd6;
  localparam logic [5:0] OP_SHR  = 6'd7;
  localparam logic [5:0] OP_EQ   = 6'd8;
  localparam logic [5:0] OP_NE   = 6'd9;
  localparam logic [5:0] OP_LT   = 6'd10;
  localparam logic [5:0] OP_GE   = 6'd11;
  localparam logic [5:0] OP_LTU  = 6'd12;
  localparam logic [5:0] OP_GEU  = 6'd13;
  localparam logic [5:0] OP_JMP  = 6'd14;
  localparam logic [5:0] OP_JMPF = 6'd15;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam int OP_LSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RA_LSB  = 18;
  localparam int RB_LSB  = 14;
  localparam int HL_BIT  = 16;
  localparam int VAL_LSB = 0;

  typedef enum logic [2:0] {CLS_WB, CLS_FLAG, CLS_BR, CLS_HALT, CLS_ILL} op_class_e;

  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_COMMIT, ST_HALT} seq_state_e;

  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD, OP_SHL, OP_SHR: return CLS_WB;
      OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU:                     return CLS_FLAG;
      OP_JMP, OP_JMPF:                                                return CLS_BR;
      OP_HALT:                                                        return CLS_HALT;
      default:                                                        return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction-word decode: op class, register indices and ALU fields.
module instr_decode
  import instr_sequencer_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [31:0]      ir_i,
  output op_class_e        cls_o,
  output logic [5:0]       op_o,
  output logic [IDX_W-1:0] rd_o,
  output logic [IDX_W-1:0] ra_o,
  output logic [IDX_W-1:0] rb_o,
  output logic             highlow_o,
  output logic [15:0]      value_o
);

  assign op_o      = ir_i[OP_LSB +: 6];
  assign cls_o     = op_class(op_o);
  assign rd_o      = ir_i[RD_LSB +: IDX_W];
  assign ra_o      = ir_i[RA_LSB +: IDX_W];
  assign rb_o      = ir_i[RB_LSB +: IDX_W];
  // highlow deliberately overlaps rb; the ALU only looks at it for the load op
  assign highlow_o = ir_i[HL_BIT];
  assign value_o   = ir_i[VAL_LSB +: 16];

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/commit sequencer driving the ALU and register file.
// Optional SEQ_ILLEGAL_TRAP_EN: ops 16-62 halt with a sticky illegal flag instead of NOP.
//   state     | meaning
//   ST_FETCH  | request mem at pc while run, capture ir on ack
//   ST_DECODE | register decoded ir fields onto rf/alu outputs
//   ST_EXEC   | sample ALU flag/branch results
//   ST_COMMIT | write back / update flags / advance pc
//   ST_HALT   | absorbing until reset
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          PC_STEP  = 4,
  parameter int          IDX_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [IDX_W-1:0] rf_ra_idx,
  output logic [IDX_W-1:0] rf_rb_idx,
  output logic [IDX_W-1:0] rf_wr_idx,
  output logic             rf_we,
  output logic [5:0]       alu_instr,
  output logic [15:0]      alu_value,
  output logic             alu_highlow,
  output logic             alu_f1,
  output logic             alu_f2,
  input  logic [31:0]      alu_c,
  input  logic             alu_flag,
  input  logic             alu_addrch,
  input  logic [31:0]      alu_naddr,
  output logic [31:0]      pc,
  output logic             halted,
  output logic             illegal
);

  seq_state_e       state_q;
  op_class_e        cls_q;
  logic [31:0]      pc_q, ir_q, naddr_q;
  logic             mem_req_q, rf_we_q, f1_q, f2_q, flag_q, addrch_q, halted_q, hl_q;
  logic [IDX_W-1:0] ra_q, rb_q, rd_q;
  logic [5:0]       instr_q;
  logic [15:0]      value_q;
  logic [31:0]      pc_inc;

  op_class_e        dec_cls;
  logic [5:0]       dec_op;
  logic [IDX_W-1:0] dec_rd, dec_ra, dec_rb;
  logic             dec_hl;
  logic [15:0]      dec_value;

  instr_decode #(.IDX_W(IDX_W)) u_decode (
    .ir_i      (ir_q),
    .cls_o     (dec_cls),
    .op_o      (dec_op),
    .rd_o      (dec_rd),
    .ra_o      (dec_ra),
    .rb_o      (dec_rb),
    .highlow_o (dec_hl),
    .value_o   (dec_value)
  );

  assign pc_inc = pc_q + 32'(PC_STEP);

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_WB;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      naddr_q   <= '0;
      mem_req_q <= 1'b0;
      rf_we_q   <= 1'b0;
      f1_q      <= 1'b0;
      f2_q      <= 1'b0;
      flag_q    <= 1'b0;
      addrch_q  <= 1'b0;
      halted_q  <= 1'b0;
      hl_q      <= 1'b0;
      ra_q      <= '0;
      rb_q      <= '0;
      rd_q      <= '0;
      instr_q   <= '0;
      value_q   <= '0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          // an ack only counts against a request that is visible on the bus
          if (mem_req_q && mem_ack) begin
            ir_q      <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= ST_DECODE;
          end else begin
            mem_req_q <= run;
          end
        end
        ST_DECODE: begin
          cls_q   <= dec_cls;
          instr_q <= dec_op;
          rd_q    <= dec_rd;
          ra_q    <= dec_ra;
          rb_q    <= dec_rb;
          hl_q    <= dec_hl;
          value_q <= dec_value;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          flag_q   <= alu_flag;
          addrch_q <= alu_addrch;
          naddr_q  <= alu_naddr;
          rf_we_q  <= (cls_q == CLS_WB);
          state_q  <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state_q   <= ST_FETCH;
          mem_req_q <= run;
          case (cls_q)
            CLS_FLAG: begin
              f1_q <= flag_q;
              f2_q <= f1_q;
              pc_q <= pc_inc;
            end
            CLS_BR:   pc_q <= addrch_q ? naddr_q : pc_inc;
            CLS_HALT: begin
              state_q   <= ST_HALT;
              halted_q  <= 1'b1;
              mem_req_q <= 1'b0;
            end
            CLS_ILL: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
              state_q   <= ST_HALT;
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
              mem_req_q <= 1'b0;
`else
              pc_q <= pc_inc;
`endif
            end
            default:  pc_q <= pc_inc;
          endcase
        end
        ST_HALT:  mem_req_q <= 1'b0;
        default:  state_q <= ST_FETCH;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign rf_ra_idx   = ra_q;
  assign rf_rb_idx   = rb_q;
  assign rf_wr_idx   = rd_q;
  assign rf_we       = rf_we_q;
  assign alu_instr   = instr_q;
  assign alu_value   = value_q;
  assign alu_highlow = hl_q;
  assign alu_f1      = f1_q;
  assign alu_f2      = f2_q;
  assign halted      = halted_q;

  // alu_c goes straight to the register file; the sequencer never consumes it
  logic unused_alu_c;
  assign unused_alu_c = ^alu_c;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; build with SEQ_ILLEGAL_TRAP_EN to cover the trap path.
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset, run, mem_req, mem_ack, rf_we;
  logic [31:0] mem_addr, mem_rdata, alu_c, alu_naddr, pc;
  logic [3:0]  rf_ra_idx, rf_rb_idx, rf_wr_idx;
  logic [5:0]  alu_instr;
  logic [15:0] alu_value;
  logic        alu_highlow, alu_f1, alu_f2, alu_flag, alu_addrch, halted, illegal;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [3:0]  ex_wr, ex_ra, ex_rb;
  logic [5:0]  ex_instr;
  logic [15:0] ex_value;
  logic        ex_hl;
  logic        cm_we;
  logic [31:0] req_addr;

  always #5 clock = ~clock;

  instr_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rf_ra_idx   (rf_ra_idx),
    .rf_rb_idx   (rf_rb_idx),
    .rf_wr_idx   (rf_wr_idx),
    .rf_we       (rf_we),
    .alu_instr   (alu_instr),
    .alu_value   (alu_value),
    .alu_highlow (alu_highlow),
    .alu_f1      (alu_f1),
    .alu_f2      (alu_f2),
    .alu_c       (alu_c),
    .alu_flag    (alu_flag),
    .alu_addrch  (alu_addrch),
    .alu_naddr   (alu_naddr),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  always @(negedge clock) if (rf_we) we_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Serve one fetch after 'waits' idle cycles, then step through DECODE/EXEC/COMMIT.
  // Returns at the first negedge after COMMIT.
  task automatic run_instr(input logic [31:0] word, input int waits, input logic flag,
                           input logic addrch, input logic [31:0] naddr);
    int n;
    alu_flag   = flag;
    alu_addrch = addrch;
    alu_naddr  = naddr;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!mem_req) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    req_addr = mem_addr;
    repeat (waits) @(negedge clock);
    mem_ack   = 1'b1;
    mem_rdata = word;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    ex_wr = rf_wr_idx; ex_ra = rf_ra_idx; ex_rb = rf_rb_idx;
    ex_instr = alu_instr; ex_value = alu_value; ex_hl = alu_highlow;
    @(negedge clock);
    cm_we = rf_we;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int we0, reqs;
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    alu_c = 32'h1234_5678; alu_flag = 1'b0; alu_addrch = 1'b0; alu_naddr = '0;
    do_reset();
    @(negedge clock);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_instr", 32'(alu_instr), 32'd0);

    // ADD rd=2 ra=0 rb=1 after 3 wait cycles
    run = 1'b1;
    we0 = we_count;
    run_instr(32'h0080_4000, 3, 1'b0, 1'b0, 32'h0);
    check("add_addr", req_addr, 32'h0);
    check("add_wr_idx", 32'(ex_wr), 32'd2);
    check("add_ra_idx", 32'(ex_ra), 32'd0);
    check("add_rb_idx", 32'(ex_rb), 32'd1);
    check("add_we_commit", 32'(cm_we), 32'd1);
    check("add_we_count", 32'(we_count - we0), 32'd1);
    check("add_pc", pc, 32'h4);

    // flag ops: op 8 with flag=1, then op 9 with flag=0
    we0 = we_count;
    run_instr(32'h2000_0000, 0, 1'b1, 1'b0, 32'h0);
    check("op8_f1", 32'(alu_f1), 32'd1);
    check("op8_f2", 32'(alu_f2), 32'd0);
    check("op8_pc", pc, 32'h8);
    run_instr(32'h2400_0000, 1, 1'b0, 1'b0, 32'h0);
    check("op9_f1", 32'(alu_f1), 32'd0);
    check("op9_f2", 32'(alu_f2), 32'd1);
    check("flag_no_we", 32'(we_count - we0), 32'd0);

    // branches
    run_instr(32'h3C00_0000, 0, 1'b0, 1'b1, 32'h0000_0100);
    check("br_taken_addr", mem_addr, 32'h100);
    run_instr(32'h3C00_0000, 2, 1'b0, 1'b0, 32'h0000_0800);
    check("br_not_taken", pc, 32'h104);

    // load with highlow=1, value=ABCD
    run_instr(32'h1401_ABCD, 0, 1'b0, 1'b0, 32'h0);
    check("ld_instr", 32'(ex_instr), 32'd5);
    check("ld_value", 32'(ex_value), 32'h0000_ABCD);
    check("ld_hl", 32'(ex_hl), 32'd1);
    check("ld_pc", pc, 32'h108);

    // reset while a fetch is outstanding; ack around it must be lost
    check("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b1; run = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1401_ABCD;
    @(negedge clock);
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_f2", 32'(alu_f2), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    mem_ack = 1'b0;
    check("late_ack_pc", pc, 32'h0);
    check("late_ack_instr", 32'(alu_instr), 32'd0);
    check("late_ack_req", 32'(mem_req), 32'd0);

    // wrap from 0xFFFF_FFFC
    run = 1'b1;
    run_instr(32'h3C00_0000, 0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_setup", pc, 32'hFFFF_FFFC);
    run_instr(32'h0000_0000, 1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", mem_addr, 32'h0);

    // illegal op 40
    run_instr(32'hA000_0000, 0, 1'b0, 1'b0, 32'h0);
`ifdef SEQ_ILLEGAL_TRAP_EN
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_pc", pc, 32'h0);
    reqs = 0;
    repeat (8) begin
      @(negedge clock);
      if (mem_req) reqs++;
    end
    check("ill_no_req", 32'(reqs), 32'd0);
`else
    check("ill_pc", pc, 32'h4);
    check("ill_flag", 32'(illegal), 32'd0);
    check("ill_halted", 32'(halted), 32'd0);
`endif

    // HALT op from a fresh reset
    do_reset();
    run = 1'b1;
    we0 = we_count;
    run_instr(32'hFC00_0000, 0, 1'b0, 1'b0, 32'h0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pc", pc, 32'h0);
    check("halt_illegal", 32'(illegal), 32'd0);
    reqs = 0;
    repeat (8) begin
      @(negedge clock);
      if (mem_req) reqs++;
    end
    check("halt_no_req", 32'(reqs), 32'd0);
    check("halt_no_we", 32'(we_count - we0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
